// File: rtl/inst_queue_pkg.sv
// Shared CPU definitions for the fetch/decode path.
// Contents: address and instruction widths, the NOP encoding, the operand-type
// encoding used by decode, and the {pc, inst} entry type held by the queue.
package inst_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    OPND_CONST = 2'b00,
    OPND_REG   = 2'b01,
    OPND_MEM   = 2'b10
  } opnd_type_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// slave  : the queue view (accepts in_*, flush, out_ready; drives the rest)
// master : the fetch/decode environment view (mirror of slave)
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Buffers up to DEPTH {pc, inst} pairs and presents them in order,
// first-word-fall-through, on a valid/ready handshake. flush discards
// everything so decode never sees wrong-path instructions.
// Ports: clk, rst (async, active-high), q (inst_queue_if.slave).
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Ready depends only on stored occupancy: a full queue refuses a push even
  // if decode pops in the same cycle, keeping out_ready off the in_ready path.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = q.in_valid & in_ready;
  assign pop       = out_valid & q.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      // Storage is left as is; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: q.in_pc, inst: q.in_inst};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.out_pc    = mem_q[rd_ptr_q].pc;
  assign q.out_inst  = mem_q[rd_ptr_q].inst;
  assign q.count     = count_q;

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ref_entry_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   last_push;
  logic [ADDR_W-1:0] next_pc;

  ref_entry_t ref_q[$];

  inst_queue_if #(.DEPTH(DEPTH)) qif ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input logic [ADDR_W-1:0] pc,
                       input logic [INST_W-1:0] inst, input bit ordy, input bit fl);
    qif.in_valid  = iv;
    qif.in_pc     = pc;
    qif.in_inst   = inst;
    qif.out_ready = ordy;
    qif.flush     = fl;
  endtask

  // Check outputs against the reference queue, apply this cycle's inputs to
  // the reference, then advance one clock. Called at posedge+1.
  task automatic cycle();
    int  n;
    bit  push;
    bit  pop;
    #3;
    n = ref_q.size();
    chk("out_valid", 64'(qif.out_valid), 64'(n != 0));
    chk("in_ready",  64'(qif.in_ready),  64'(n < DEPTH));
    chk("count",     64'(qif.count),     64'(n));
    if (n != 0) begin
      chk("out_pc",   64'(qif.out_pc),   64'(ref_q[0].pc));
      chk("out_inst", 64'(qif.out_inst), 64'(ref_q[0].inst));
    end
    push = qif.in_valid && (n < DEPTH);
    pop  = qif.out_ready && (n != 0);
    last_push = push && !qif.flush;
    if (qif.flush) begin
      ref_q.delete();
    end else begin
      if (pop)  void'(ref_q.pop_front());
      if (push) ref_q.push_back('{pc: qif.in_pc, inst: qif.in_inst});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_out_valid", 64'(qif.out_valid), 64'd0);
    chk("rst_in_ready",  64'(qif.in_ready),  64'd1);
    chk("rst_count",     64'(qif.count),     64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_out_pc",   64'(qif.out_pc),   64'd0);
    chk("idle_out_inst", 64'(qif.out_inst), 64'd0);
    cycle();

    // Fill to full with decode stalled, try a fifth push, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(4 * i), 32'h1111_0000 + INST_W'(4 * i), 1'b0, 1'b0);
      cycle();
    end
    chk("full_count",    64'(qif.count),    64'd4);
    chk("full_in_ready", 64'(qif.in_ready), 64'd0);
    drive(1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0);
    cycle();
    chk("reject_count", 64'(qif.count), 64'd4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle();

    // Full queue with push and pop together: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20 + ADDR_W'(4 * i), 32'h2222_0000 + INST_W'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle();
    chk("fullpp_count", 64'(qif.count), 64'd3);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    // Continuous stream from empty: wraps the pointers twice.
    next_pc = 32'h200;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, next_pc, 32'h3333_0000 ^ next_pc, 1'b1, 1'b0);
      cycle();
      if (last_push) next_pc = next_pc + 4;
      if (i > 0) chk("stream_count", 64'(qif.count), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();

    // Flush with three queued entries and a push pending.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + ADDR_W'(4 * i), 32'h4444_0000 + INST_W'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h40, 32'h5555_0040, 1'b0, 1'b1);
    cycle();
    chk("flush_count",     64'(qif.count),     64'd0);
    chk("flush_out_valid", 64'(qif.out_valid), 64'd0);
    drive(1'b1, 32'h80, 32'h5555_0080, 1'b0, 1'b0);
    cycle();
    chk("after_flush_pc", 64'(qif.out_pc), 64'h80);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Asynchronous reset between edges with two entries held.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h60 + ADDR_W'(4 * i), 32'h6666_0000 + INST_W'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_arst_count", 64'(qif.count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(qif.out_valid), 64'd0);
    chk("arst_count",     64'(qif.count),     64'd0);
    chk("arst_in_ready",  64'(qif.in_ready),  64'd1);
    chk("arst_out_pc",    64'(qif.out_pc),    64'd0);
    chk("arst_out_inst",  64'(qif.out_inst),  64'd0);
    ref_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Randomized traffic against the reference queue.
    next_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, next_pc, $urandom, ($urandom % 3) != 0,
            ($urandom % 25) == 0);
      cycle();
      if (last_push) next_pc = next_pc + 4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
